id_ex_stage: RTL and testbench

ID/EX pipeline register with integrated load-use hazard detection for the 5-stage MIPS core. It sits directly downstream of the instruction decoder and captures the decoded control bundle, operands and destination selection each cycle. It inserts a one-cycle bubble and requests an upstream stall on a load-use hazard, and it squashes the ID instruction when EX resolves a taken branch or jump-register redirect.

---
 rtl/id_ex_stage.sv | 196 +++++++++++++++++++
 tb/tb_id_ex_stage.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register for the 5-stage MIPS core, with
// load-use hazard detection and branch/jump-register squash.
//
// Ports:
//   clk, rst_n        pipeline clock, asynchronous active-low reset
//   id_valid          ID stage holds a real instruction
//   id_<ctrl>         decoder control bits (reg_dst ... lu_op)
//   id_opcode/funct   instruction fields for EX ALU control
//   id_pc_plus4, id_rs_data, id_rt_data, id_imm_ext   DW-bit datapath
//   id_rs/rt/rd/shamt 5-bit register and shift fields
//   flush_i           EX-resolved redirect, squashes the ID instruction
//   stall_o           combinational: hold PC and IF/ID this cycle
//   ex_*              registered copies of the id_* inputs
//   ex_valid          EX slot holds a real instruction
//   ex_wr_addr        resolved destination register
//   stall_count, flush_count   CW-bit wrapping event counters
//
// Stall contract: stall_o is a hold request to the upstream stages. While it
// is high this stage takes a bubble and expects IF/ID to present the same
// instruction again on the next cycle.
module id_ex_stage #(
  parameter int DW = 32,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          id_valid,
  input  logic          id_reg_dst,
  input  logic          id_jal_write,
  input  logic          id_alu_src1,
  input  logic          id_alu_src2,
  input  logic          id_branch,
  input  logic          id_mem_read,
  input  logic          id_mem_write,
  input  logic          id_reg_write,
  input  logic          id_mem_to_reg,
  input  logic          id_ext_op,
  input  logic          id_lu_op,
  input  logic [5:0]    id_opcode,
  input  logic [5:0]    id_funct,
  input  logic [DW-1:0] id_pc_plus4,
  input  logic [DW-1:0] id_rs_data,
  input  logic [DW-1:0] id_rt_data,
  input  logic [DW-1:0] id_imm_ext,
  input  logic [4:0]    id_rs,
  input  logic [4:0]    id_rt,
  input  logic [4:0]    id_rd,
  input  logic [4:0]    id_shamt,
  input  logic          flush_i,
  output logic          stall_o,
  output logic          ex_valid,
  output logic          ex_reg_dst,
  output logic          ex_jal_write,
  output logic          ex_alu_src1,
  output logic          ex_alu_src2,
  output logic          ex_branch,
  output logic          ex_mem_read,
  output logic          ex_mem_write,
  output logic          ex_reg_write,
  output logic          ex_mem_to_reg,
  output logic          ex_ext_op,
  output logic          ex_lu_op,
  output logic [5:0]    ex_opcode,
  output logic [5:0]    ex_funct,
  output logic [DW-1:0] ex_pc_plus4,
  output logic [DW-1:0] ex_rs_data,
  output logic [DW-1:0] ex_rt_data,
  output logic [DW-1:0] ex_imm_ext,
  output logic [4:0]    ex_rs,
  output logic [4:0]    ex_rt,
  output logic [4:0]    ex_rd,
  output logic [4:0]    ex_shamt,
  output logic [4:0]    ex_wr_addr,
  output logic [CW-1:0] stall_count,
  output logic [CW-1:0] flush_count
);

  typedef struct packed {
    logic          valid;
    logic          reg_dst;
    logic          jal_write;
    logic          alu_src1;
    logic          alu_src2;
    logic          branch;
    logic          mem_read;
    logic          mem_write;
    logic          reg_write;
    logic          mem_to_reg;
    logic          ext_op;
    logic          lu_op;
    logic [5:0]    opcode;
    logic [5:0]    funct;
    logic [DW-1:0] pc_plus4;
    logic [DW-1:0] rs_data;
    logic [DW-1:0] rt_data;
    logic [DW-1:0] imm_ext;
    logic [4:0]    rs;
    logic [4:0]    rt;
    logic [4:0]    rd;
    logic [4:0]    shamt;
    logic [4:0]    wr_addr;
  } pipe_t;

  pipe_t         pipe_d, pipe_q;
  logic [CW-1:0] stall_count_d, stall_count_q;
  logic [CW-1:0] flush_count_d, flush_count_q;
  logic [4:0]    id_wr_addr;
  logic          hazard;

  always_comb begin
    // jal links into $ra; R-type writes rd; I-type writes rt.
    id_wr_addr = id_rt;
    if (id_jal_write)    id_wr_addr = 5'd31;
    else if (id_reg_dst) id_wr_addr = id_rd;

    // A load in EX cannot forward in time to an ID consumer. $zero is never
    // a real dependency, even for an lw targeting it.
    hazard = pipe_q.valid & pipe_q.mem_read & pipe_q.reg_write &
             (pipe_q.wr_addr != 5'd0) & id_valid &
             ((pipe_q.wr_addr == id_rs) | (pipe_q.wr_addr == id_rt));

    // A redirect kills the ID instruction, so there is nothing left to stall.
    stall_o = hazard & ~flush_i;

    pipe_d = '0;
    if (!(flush_i || hazard)) begin
      pipe_d.valid      = id_valid;
      pipe_d.reg_dst    = id_reg_dst;
      pipe_d.jal_write  = id_jal_write & id_valid;
      pipe_d.alu_src1   = id_alu_src1;
      pipe_d.alu_src2   = id_alu_src2;
      pipe_d.branch     = id_branch & id_valid;
      pipe_d.mem_read   = id_mem_read & id_valid;
      pipe_d.mem_write  = id_mem_write & id_valid;
      pipe_d.reg_write  = id_reg_write & id_valid;
      pipe_d.mem_to_reg = id_mem_to_reg;
      pipe_d.ext_op     = id_ext_op;
      pipe_d.lu_op      = id_lu_op;
      pipe_d.opcode     = id_opcode;
      pipe_d.funct      = id_funct;
      pipe_d.pc_plus4   = id_pc_plus4;
      pipe_d.rs_data    = id_rs_data;
      pipe_d.rt_data    = id_rt_data;
      pipe_d.imm_ext    = id_imm_ext;
      pipe_d.rs         = id_rs;
      pipe_d.rt         = id_rt;
      pipe_d.rd         = id_rd;
      pipe_d.shamt      = id_shamt;
      pipe_d.wr_addr    = id_wr_addr;
    end

    stall_count_d = stall_count_q;
    if (stall_o) stall_count_d = stall_count_q + CW'(1);
    flush_count_d = flush_count_q;
    if (flush_i && id_valid) flush_count_d = flush_count_q + CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_q        <= '0;
      stall_count_q <= '0;
      flush_count_q <= '0;
    end else begin
      pipe_q        <= pipe_d;
      stall_count_q <= stall_count_d;
      flush_count_q <= flush_count_d;
    end
  end

  assign ex_valid      = pipe_q.valid;
  assign ex_reg_dst    = pipe_q.reg_dst;
  assign ex_jal_write  = pipe_q.jal_write;
  assign ex_alu_src1   = pipe_q.alu_src1;
  assign ex_alu_src2   = pipe_q.alu_src2;
  assign ex_branch     = pipe_q.branch;
  assign ex_mem_read   = pipe_q.mem_read;
  assign ex_mem_write  = pipe_q.mem_write;
  assign ex_reg_write  = pipe_q.reg_write;
  assign ex_mem_to_reg = pipe_q.mem_to_reg;
  assign ex_ext_op     = pipe_q.ext_op;
  assign ex_lu_op      = pipe_q.lu_op;
  assign ex_opcode     = pipe_q.opcode;
  assign ex_funct      = pipe_q.funct;
  assign ex_pc_plus4   = pipe_q.pc_plus4;
  assign ex_rs_data    = pipe_q.rs_data;
  assign ex_rt_data    = pipe_q.rt_data;
  assign ex_imm_ext    = pipe_q.imm_ext;
  assign ex_rs         = pipe_q.rs;
  assign ex_rt         = pipe_q.rt;
  assign ex_rd         = pipe_q.rd;
  assign ex_shamt      = pipe_q.shamt;
  assign ex_wr_addr    = pipe_q.wr_addr;
  assign stall_count   = stall_count_q;
  assign flush_count   = flush_count_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed bench for id_ex_stage. The counter width is
// reduced to 8 so that the wrap case stays short.
module tb_id_ex_stage;
  localparam int DW = 32;
  localparam int CW = 8;

  logic          clk, rst_n;
  logic          id_valid, id_reg_dst, id_jal_write, id_alu_src1, id_alu_src2;
  logic          id_branch, id_mem_read, id_mem_write, id_reg_write;
  logic          id_mem_to_reg, id_ext_op, id_lu_op;
  logic [5:0]    id_opcode, id_funct;
  logic [DW-1:0] id_pc_plus4, id_rs_data, id_rt_data, id_imm_ext;
  logic [4:0]    id_rs, id_rt, id_rd, id_shamt;
  logic          flush_i, stall_o;
  logic          ex_valid, ex_reg_dst, ex_jal_write, ex_alu_src1, ex_alu_src2;
  logic          ex_branch, ex_mem_read, ex_mem_write, ex_reg_write;
  logic          ex_mem_to_reg, ex_ext_op, ex_lu_op;
  logic [5:0]    ex_opcode, ex_funct;
  logic [DW-1:0] ex_pc_plus4, ex_rs_data, ex_rt_data, ex_imm_ext;
  logic [4:0]    ex_rs, ex_rt, ex_rd, ex_shamt, ex_wr_addr;
  logic [CW-1:0] stall_count, flush_count;

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] exp_q[$];

  id_ex_stage #(.DW(DW), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_reg_dst(id_reg_dst), .id_jal_write(id_jal_write),
    .id_alu_src1(id_alu_src1), .id_alu_src2(id_alu_src2),
    .id_branch(id_branch), .id_mem_read(id_mem_read),
    .id_mem_write(id_mem_write), .id_reg_write(id_reg_write),
    .id_mem_to_reg(id_mem_to_reg), .id_ext_op(id_ext_op), .id_lu_op(id_lu_op),
    .id_opcode(id_opcode), .id_funct(id_funct), .id_pc_plus4(id_pc_plus4),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm_ext(id_imm_ext),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_shamt(id_shamt),
    .flush_i(flush_i), .stall_o(stall_o), .ex_valid(ex_valid),
    .ex_reg_dst(ex_reg_dst), .ex_jal_write(ex_jal_write),
    .ex_alu_src1(ex_alu_src1), .ex_alu_src2(ex_alu_src2),
    .ex_branch(ex_branch), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_reg_write(ex_reg_write),
    .ex_mem_to_reg(ex_mem_to_reg), .ex_ext_op(ex_ext_op), .ex_lu_op(ex_lu_op),
    .ex_opcode(ex_opcode), .ex_funct(ex_funct), .ex_pc_plus4(ex_pc_plus4),
    .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm_ext(ex_imm_ext),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_shamt(ex_shamt),
    .ex_wr_addr(ex_wr_addr), .stall_count(stall_count),
    .flush_count(flush_count)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // checking
  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // drivers
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_nop();
    id_valid = 1'b0; id_reg_dst = 1'b0; id_jal_write = 1'b0;
    id_alu_src1 = 1'b0; id_alu_src2 = 1'b0; id_branch = 1'b0;
    id_mem_read = 1'b0; id_mem_write = 1'b0; id_reg_write = 1'b0;
    id_mem_to_reg = 1'b0; id_ext_op = 1'b0; id_lu_op = 1'b0;
    id_opcode = 6'd0; id_funct = 6'd0; id_pc_plus4 = '0;
    id_rs_data = '0; id_rt_data = '0; id_imm_ext = '0;
    id_rs = 5'd0; id_rt = 5'd0; id_rd = 5'd0; id_shamt = 5'd0;
  endtask

  task automatic drive_rtype(input logic [5:0] funct, input logic [4:0] rd,
                             input logic [4:0] rs, input logic [4:0] rt,
                             input logic [31:0] rs_d, input logic [31:0] rt_d);
    drive_nop();
    id_valid = 1'b1; id_reg_dst = 1'b1; id_reg_write = 1'b1;
    id_funct = funct; id_rd = rd; id_rs = rs; id_rt = rt;
    id_rs_data = rs_d; id_rt_data = rt_d; id_pc_plus4 = 32'h0000_0104;
  endtask

  task automatic drive_lw(input logic [4:0] rt, input logic [4:0] rs);
    drive_nop();
    id_valid = 1'b1; id_opcode = 6'h23; id_mem_read = 1'b1;
    id_reg_write = 1'b1; id_mem_to_reg = 1'b1; id_alu_src2 = 1'b1;
    id_ext_op = 1'b1; id_rt = rt; id_rs = rs;
  endtask

  task automatic drive_jal(input logic [4:0] rd);
    drive_nop();
    id_valid = 1'b1; id_opcode = 6'h03; id_jal_write = 1'b1;
    id_reg_write = 1'b1; id_rd = rd;
  endtask

  initial begin
    rst_n = 1'b0;
    flush_i = 1'b0;
    drive_rtype(6'h21, 5'd3, 5'd1, 5'd2, 32'h11, 32'h22);
    #3;
    check("rst_ex_valid", {31'd0, ex_valid}, 32'd0);
    check("rst_wr_addr", {27'd0, ex_wr_addr}, 32'd0);
    check("rst_stall_o", {31'd0, stall_o}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // addu $3,$1,$2
    @(negedge clk);
    check("add_stall_o", {31'd0, stall_o}, 32'd0);
    step();
    check("add_valid", {31'd0, ex_valid}, 32'd1);
    check("add_wr_addr", {27'd0, ex_wr_addr}, 32'd3);
    check("add_rs_data", ex_rs_data, 32'h11);
    check("add_rt_data", ex_rt_data, 32'h22);
    check("add_reg_write", {31'd0, ex_reg_write}, 32'd1);
    check("add_funct", {26'd0, ex_funct}, 32'h21);

    // back-to-back stream: each instruction appears one cycle after capture
    for (int i = 0; i < 4; i++) begin
      drive_rtype(6'h21, 5'(10 + i), 5'd1, 5'd2, 32'hA0 + 32'(i), 32'h0);
      exp_q.push_back(32'hA0 + 32'(i));
      step();
      check("stream_rs_data", ex_rs_data, exp_q.pop_front());
    end

    // lw $5,0($1) ; add $6,$5,$2
    drive_lw(5'd5, 5'd1);
    step();
    check("lw_mem_read", {31'd0, ex_mem_read}, 32'd1);
    check("lw_wr_addr", {27'd0, ex_wr_addr}, 32'd5);
    drive_rtype(6'h20, 5'd6, 5'd5, 5'd2, 32'h0, 32'h0);
    @(negedge clk);
    check("lu_stall_o", {31'd0, stall_o}, 32'd1);
    step();
    check("lu_bubble_valid", {31'd0, ex_valid}, 32'd0);
    check("lu_bubble_mem_read", {31'd0, ex_mem_read}, 32'd0);
    check("lu_bubble_reg_write", {31'd0, ex_reg_write}, 32'd0);
    check("lu_stall_count", 32'(stall_count), 32'd1);
    @(negedge clk);
    check("lu_stall_release", {31'd0, stall_o}, 32'd0);
    step();
    check("lu_add_valid", {31'd0, ex_valid}, 32'd1);
    check("lu_add_wr_addr", {27'd0, ex_wr_addr}, 32'd6);
    check("lu_stall_count2", 32'(stall_count), 32'd1);

    // lw $0 followed by a use of $0
    drive_lw(5'd0, 5'd1);
    step();
    drive_rtype(6'h21, 5'd4, 5'd0, 5'd0, 32'h0, 32'h0);
    @(negedge clk);
    check("zero_stall_o", {31'd0, stall_o}, 32'd0);
    step();
    check("zero_wr_addr", {27'd0, ex_wr_addr}, 32'd4);
    check("zero_valid", {31'd0, ex_valid}, 32'd1);

    // invalid ID with reg_write set
    drive_rtype(6'h21, 5'd8, 5'd1, 5'd2, 32'h5, 32'h6);
    id_valid = 1'b0;
    step();
    check("inv_valid", {31'd0, ex_valid}, 32'd0);
    check("inv_reg_write", {31'd0, ex_reg_write}, 32'd0);
    check("inv_wr_addr", {27'd0, ex_wr_addr}, 32'd8);

    // load-use plus flush in the same cycle
    drive_lw(5'd5, 5'd1);
    step();
    drive_rtype(6'h20, 5'd6, 5'd5, 5'd2, 32'h0, 32'h0);
    flush_i = 1'b1;
    @(negedge clk);
    check("fl_stall_o", {31'd0, stall_o}, 32'd0);
    step();
    flush_i = 1'b0;
    check("fl_valid", {31'd0, ex_valid}, 32'd0);
    check("fl_reg_write", {31'd0, ex_reg_write}, 32'd0);
    check("fl_rs_data", ex_rs_data, 32'd0);
    check("fl_flush_count", 32'(flush_count), 32'd1);
    check("fl_stall_count", 32'(stall_count), 32'd1);

    // jal with rd = 7
    drive_jal(5'd7);
    step();
    check("jal_wr_addr", {27'd0, ex_wr_addr}, 32'd31);
    check("jal_jal_write", {31'd0, ex_jal_write}, 32'd1);

    // asynchronous reset mid-cycle, then a normal load after release
    drive_rtype(6'h21, 5'd9, 5'd1, 5'd2, 32'hAB, 32'hCD);
    step();
    check("pre_rst_rs_data", ex_rs_data, 32'hAB);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", {31'd0, ex_valid}, 32'd0);
    check("arst_rs_data", ex_rs_data, 32'd0);
    check("arst_wr_addr", {27'd0, ex_wr_addr}, 32'd0);
    check("arst_stall_count", 32'(stall_count), 32'd0);
    check("arst_flush_count", 32'(flush_count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("post_rst_valid", {31'd0, ex_valid}, 32'd1);
    check("post_rst_rs_data", ex_rs_data, 32'hAB);
    check("post_rst_wr_addr", {27'd0, ex_wr_addr}, 32'd9);

    // counter wrap: lw $5,0($5) held forever stalls every other cycle
    drive_lw(5'd5, 5'd5);
    for (int i = 0; i < 510; i++) step();
    check("wrap_pre", 32'(stall_count), 32'd255);
    step();
    step();
    check("wrap_zero", 32'(stall_count), 32'd0);
    check("wrap_bubble", {31'd0, ex_valid}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, %0d/%0d so far", n_pass, n_checks);
    $fatal(1);
  end

endmodule
